niosii_demo_led_fader: RTL and testbench
========================================

// Module: niosII_demo_led_fader
// PURPOSE
//   Downstream consumer of the LED PIO: takes the 10-bit LED pattern register output and drives
//   the board LEDs with per-LED PWM brightness that ramps smoothly up/down on pattern changes.
//   Sits between the PIO out_port and the LEDR pins; no bus interface, pure datapath plus timers.
// PARAMETERS
//   WIDTH      10  number of LEDs (matches PIO out_port width)
//   PWM_BITS   8   PWM counter / brightness level width; period = 2**PWM_BITS clk cycles
//   FADE_STEP  16  brightness change per fade update (1..2**PWM_BITS-1)
//   FADE_DIV   4   PWM periods between fade updates (>=1)
// PORTS
//   clk        in   1         system clock, all logic on rising edge
//   reset_n    in   1         asynchronous active-low reset
//   led_in     in   WIDTH     LED pattern from PIO out_port (same clock domain)
//   fade_en    in   1         1 = ramp levels; 0 = levels snap to target (no fade)
//   led_out    out  WIDTH     PWM-modulated LED drive, registered
//   busy       out  1         1 while any LED level is not at its target (0 or MAX)
// BEHAVIOUR
//   - MAX = 2**PWM_BITS-1. Reset (reset_n=0, async): led_req, level[*], pwm_cnt, div_cnt,
//     led_out, busy all 0. Reset mid-fade discards levels; ramp restarts from 0 on release.
//   - led_req <= led_in every cycle (1-cycle registered copy); target[i] = led_req[i] ? MAX : 0.
//   - pwm_cnt: PWM_BITS-bit free-running, +1 every cycle, wraps MAX->0. wrap = (pwm_cnt==MAX).
//   - div_cnt: counts wraps 0..FADE_DIV-1; upd = wrap && div_cnt==FADE_DIV-1; div_cnt->0 on upd.
//   - Level update, per LED i, evaluated each cycle, priority top-down:
//       fade_en==0                : level[i] <= target[i] (next cycle, independent of upd)
//       upd && led_req[i]==1      : level[i] <= min(level[i]+FADE_STEP, MAX), sum in PWM_BITS+1
//       upd && led_req[i]==0      : level[i] <= max(level[i]-FADE_STEP, 0), no underflow wrap
//       otherwise                 : hold
//   - Pattern change mid-ramp: direction follows new led_req at the next upd; no restart of level.
//   - led_out[i] <= (level[i]==MAX) ? 1 : (level[i] > pwm_cnt). level 0 -> constant 0;
//     level MAX -> constant 1; level L otherwise -> high for exactly L cycles per 2**PWM_BITS period.
//   - Level change takes effect on led_out one cycle after level register updates (registered cmp).
//   - busy <= OR over i of (level[i] != target[i]); registered, 1-cycle lag.
//   - fade_en falling 1->0 mid-ramp: all levels reach target on the next cycle; busy drops 1 cycle
//     later. fade_en 0->1: no immediate change; subsequent pattern edges ramp.
//   - Simultaneous upd and led_in change: upd uses current led_req (pre-change value).
//   - Full ramp 0->MAX needs ceil(MAX/FADE_STEP) updates = that many * FADE_DIV * 2**PWM_BITS clks.
// TESTING (bench with defaults unless noted)
//   1. Reset held, toggle led_in -> led_out=0, busy=0; release async mid-cycle -> counters start at 0.
//   2. fade_en=1, led_in=10'h001 -> busy=1 one cycle after led_req; level0 steps 16,32..240,255
//      every 1024 clks; after 16 updates led_out[0] constant 1, busy=0; other LEDs stay 0.
//   3. Duty check: FADE_DIV=1, stop at level0=64 -> led_out[0] high exactly 64 of each 256 clks.
//   4. At level0=128 (rising) set led_in=0 -> next upd gives 112, then down to 0, saturates, no wrap.
//   5. fade_en=0, led_in=10'h3FF -> all levels MAX next cycle, led_out=10'h3FF a cycle later, busy=0.
//   6. FADE_STEP=255 -> single update goes 0->255 and 255->0; no overflow past MAX or below 0.

Source files
------------

// File: rtl/niosii_demo_led_fader.sv
// Per-LED PWM driver that fades each LED towards full on/off whenever the PIO pattern changes.
// Latency: led_in -> led_req 1 clk, level -> led_out 1 clk, level -> busy 1 clk.
// Backpressure: none; free-running datapath with no handshake.
module niosii_demo_led_fader #(
    parameter int WIDTH     = 10,
    parameter int PWM_BITS  = 8,
    parameter int FADE_STEP = 16,
    parameter int FADE_DIV  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] led_in,
    input  logic             fade_en,
    output logic [WIDTH-1:0] led_out,
    output logic             busy
);

    localparam logic [PWM_BITS-1:0] MAX      = {PWM_BITS{1'b1}};
    localparam int                  DIV_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(FADE_DIV - 1);
    localparam logic [PWM_BITS:0]   STEP     = (PWM_BITS + 1)'(FADE_STEP);

    logic [WIDTH-1:0]    r_led_req;
    logic [PWM_BITS-1:0] r_level [WIDTH];
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [DIV_W-1:0]    r_div_cnt;
    logic [WIDTH-1:0]    r_led_out;
    logic                r_busy;

    logic                w_wrap;
    logic                w_upd;
    logic [PWM_BITS-1:0] w_level_nxt [WIDTH];
    logic [WIDTH-1:0]    w_pwm_hi;
    logic [WIDTH-1:0]    w_off_target;

    assign w_wrap = (r_pwm_cnt == MAX);
    assign w_upd  = w_wrap && (r_div_cnt == DIV_LAST);

    // Fade updates fire once every FADE_DIV complete PWM periods.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pwm_cnt <= '0;
            r_div_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (w_upd) begin
                r_div_cnt <= '0;
            end else if (w_wrap) begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_led
        logic [PWM_BITS-1:0] w_target;
        logic [PWM_BITS:0]   w_sum;
        logic [PWM_BITS-1:0] w_up;
        logic [PWM_BITS-1:0] w_dn;

        assign w_target = r_led_req[g] ? MAX : '0;
        // Sum carries one extra bit so the ramp saturates at MAX instead of wrapping.
        assign w_sum    = {1'b0, r_level[g]} + STEP;
        assign w_up     = w_sum[PWM_BITS] ? MAX : w_sum[PWM_BITS-1:0];
        assign w_dn     = ({1'b0, r_level[g]} >= STEP) ? (r_level[g] - STEP[PWM_BITS-1:0]) : '0;

        assign w_level_nxt[g]  = !fade_en     ? w_target   :
                                 !w_upd       ? r_level[g] :
                                 r_led_req[g] ? w_up       : w_dn;

        assign w_pwm_hi[g]     = (r_level[g] == MAX) || (r_level[g] > r_pwm_cnt);
        assign w_off_target[g] = (r_level[g] != w_target);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_led_req <= '0;
            r_led_out <= '0;
            r_busy    <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_level[i] <= '0;
            end
        end else begin
            r_led_req <= led_in;
            r_led_out <= w_pwm_hi;
            r_busy    <= |w_off_target;
            for (int i = 0; i < WIDTH; i++) begin
                r_level[i] <= w_level_nxt[i];
            end
        end
    end

    assign led_out = r_led_out;
    assign busy    = r_busy;

endmodule

// File: tb/tb_niosii_demo_led_fader.sv
// Directed bench for niosii_demo_led_fader: three instances (default, FADE_DIV=1, FADE_STEP=255).
// Latency: n/a. Backpressure: n/a.
module tb_niosii_demo_led_fader;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] led_in_a, led_in_b, led_in_c;
    logic       fade_en_a, fade_en_b, fade_en_c;
    logic [9:0] led_out_a, led_out_b, led_out_c;
    logic       busy_a, busy_b, busy_c;

    int cyc;
    int n_tests;
    int n_fail;
    int exp_up   [16] = '{16, 32, 48, 64, 80, 96, 112, 128, 144, 160, 176, 192, 208, 224, 240, 256};
    int exp_down [9]  = '{112, 96, 80, 64, 48, 32, 16, 0, 0};

    always #5 clk = ~clk;

    niosii_demo_led_fader dut_a (
        .clk(clk), .reset_n(reset_n), .led_in(led_in_a), .fade_en(fade_en_a),
        .led_out(led_out_a), .busy(busy_a)
    );

    niosii_demo_led_fader #(.WIDTH(10), .PWM_BITS(8), .FADE_STEP(16), .FADE_DIV(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .led_in(led_in_b), .fade_en(fade_en_b),
        .led_out(led_out_b), .busy(busy_b)
    );

    niosii_demo_led_fader #(.WIDTH(10), .PWM_BITS(8), .FADE_STEP(255), .FADE_DIV(4)) dut_c (
        .clk(clk), .reset_n(reset_n), .led_in(led_in_c), .fade_en(fade_en_c),
        .led_out(led_out_c), .busy(busy_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) tick();
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        led_in_a  = '0; led_in_b  = '0; led_in_c  = '0;
        fade_en_a = 1'b0; fade_en_b = 1'b0; fade_en_c = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    // Number of cycles led_out[0] of the selected instance is high over samples first..last.
    task automatic count_hi(input int sel, input int first, input int last, output int n);
        wait_cyc(first - 1);
        n = 0;
        repeat (last - first + 1) begin
            tick();
            case (sel)
                0:       n += int'(led_out_a[0]);
                1:       n += int'(led_out_b[0]);
                default: n += int'(led_out_c[0]);
            endcase
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            led_in_a  = i[0] ? 10'h3FF : 10'h155;
            led_in_b  = led_in_a;
            led_in_c  = led_in_a;
            fade_en_a = i[1];
            fade_en_b = i[1];
            fade_en_c = i[1];
            tick();
            n_tests++;
            if ({led_out_a, led_out_b, led_out_c, busy_a, busy_b, busy_c} !== 33'h0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: out=%h/%h/%h busy=%b%b%b expected all 0",
                         i, led_out_a, led_out_b, led_out_c, busy_a, busy_b, busy_c);
            end
        end
        @(negedge clk);
        reset_n   = 1'b1;
        cyc       = 0;
        led_in_a  = '0; led_in_b  = '0; led_in_c  = '0;
        fade_en_a = 1'b1; fade_en_b = 1'b1; fade_en_c = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({led_out_a, led_out_b, led_out_c, busy_a, busy_b, busy_c} !== 33'h0) begin
            n_fail++;
            $display("FAIL reset_release: out=%h/%h/%h busy=%b%b%b expected all 0",
                     led_out_a, led_out_b, led_out_c, busy_a, busy_b, busy_c);
        end
    endtask

    task automatic test_ramp_up();
        int cnt;
        int base;
        do_reset();
        fade_en_a = 1'b1;
        led_in_a  = 10'h001;
        tick();
        n_tests++;
        if (busy_a !== 1'b0) begin
            n_fail++; $display("FAIL ramp_busy_c1: got %b expected 0", busy_a);
        end
        tick();
        n_tests++;
        if (busy_a !== 1'b1) begin
            n_fail++; $display("FAIL ramp_busy_c2: got %b expected 1", busy_a);
        end
        wait_cyc(1024);
        n_tests++;
        if (led_out_a[0] !== 1'b0) begin
            n_fail++; $display("FAIL ramp_first_upd_c1024: got %b expected 0", led_out_a[0]);
        end
        tick();
        n_tests++;
        if (led_out_a[0] !== 1'b1) begin
            n_fail++; $display("FAIL ramp_first_upd_c1025: got %b expected 1", led_out_a[0]);
        end
        for (int n = 0; n < 16; n++) begin
            base = 1024 * (n + 1);
            if (n == 15) begin
                wait_cyc(base);
                n_tests++;
                if (busy_a !== 1'b1) begin
                    n_fail++; $display("FAIL ramp_busy_last_upd: got %b expected 1", busy_a);
                end
                tick();
                n_tests++;
                if (busy_a !== 1'b0) begin
                    n_fail++; $display("FAIL ramp_busy_done: got %b expected 0", busy_a);
                end
            end
            count_hi(0, base + 2, base + 257, cnt);
            n_tests++;
            if (cnt !== exp_up[n]) begin
                n_fail++; $display("FAIL ramp_duty[%0d]: got %0d expected %0d", n, cnt, exp_up[n]);
            end
            n_tests++;
            if (led_out_a[9:1] !== 9'h0) begin
                n_fail++; $display("FAIL ramp_others[%0d]: got %h expected 0", n, led_out_a[9:1]);
            end
        end
    endtask

    task automatic test_duty();
        int cnt;
        do_reset();
        fade_en_b = 1'b1;
        led_in_b  = 10'h001;
        count_hi(1, 1025, 1280, cnt);
        n_tests++;
        if (cnt !== 64) begin
            n_fail++; $display("FAIL duty_64: got %0d expected 64", cnt);
        end
        count_hi(1, 2049, 2304, cnt);
        n_tests++;
        if (cnt !== 128) begin
            n_fail++; $display("FAIL duty_128: got %0d expected 128", cnt);
        end
    endtask

    task automatic test_ramp_down();
        int cnt;
        int base;
        do_reset();
        fade_en_a = 1'b1;
        led_in_a  = 10'h001;
        count_hi(0, 8194, 8449, cnt);
        n_tests++;
        if (cnt !== 128) begin
            n_fail++; $display("FAIL down_start_128: got %0d expected 128", cnt);
        end
        led_in_a = 10'h000;
        for (int m = 0; m < 9; m++) begin
            base = 9216 + 1024 * m;
            if (m == 7) begin
                wait_cyc(base);
                n_tests++;
                if (busy_a !== 1'b1) begin
                    n_fail++; $display("FAIL down_busy_last_upd: got %b expected 1", busy_a);
                end
                tick();
                n_tests++;
                if (busy_a !== 1'b0) begin
                    n_fail++; $display("FAIL down_busy_done: got %b expected 0", busy_a);
                end
            end
            count_hi(0, base + 2, base + 257, cnt);
            n_tests++;
            if (cnt !== exp_down[m]) begin
                n_fail++; $display("FAIL down_duty[%0d]: got %0d expected %0d", m, cnt, exp_down[m]);
            end
        end
    endtask

    task automatic test_snap();
        do_reset();
        fade_en_a = 1'b0;
        repeat (2) tick();
        led_in_a = 10'h3FF;
        tick();
        n_tests++;
        if (led_out_a !== 10'h000 || busy_a !== 1'b0) begin
            n_fail++; $display("FAIL snap_c3: out=%h busy=%b expected 000/0", led_out_a, busy_a);
        end
        tick();
        n_tests++;
        if (led_out_a !== 10'h000 || busy_a !== 1'b1) begin
            n_fail++; $display("FAIL snap_c4: out=%h busy=%b expected 000/1", led_out_a, busy_a);
        end
        tick();
        n_tests++;
        if (led_out_a !== 10'h3FF || busy_a !== 1'b0) begin
            n_fail++; $display("FAIL snap_c5: out=%h busy=%b expected 3ff/0", led_out_a, busy_a);
        end
        tick();
        n_tests++;
        if (led_out_a !== 10'h3FF) begin
            n_fail++; $display("FAIL snap_hold: out=%h expected 3ff", led_out_a);
        end
    endtask

    task automatic test_fade_en_fall();
        int cnt;
        do_reset();
        fade_en_a = 1'b1;
        led_in_a  = 10'h001;
        wait_cyc(2050);
        fade_en_a = 1'b0;
        tick();
        n_tests++;
        if (busy_a !== 1'b1) begin
            n_fail++; $display("FAIL fall_busy_c1: got %b expected 1", busy_a);
        end
        tick();
        n_tests++;
        if (busy_a !== 1'b0 || led_out_a[0] !== 1'b1) begin
            n_fail++; $display("FAIL fall_c2: busy=%b led0=%b expected 0/1", busy_a, led_out_a[0]);
        end
        count_hi(0, 2053, 2308, cnt);
        n_tests++;
        if (cnt !== 256) begin
            n_fail++; $display("FAIL fall_full_on: got %0d expected 256", cnt);
        end
        fade_en_a = 1'b1;
        tick();
        n_tests++;
        if (busy_a !== 1'b0 || led_out_a[0] !== 1'b1) begin
            n_fail++; $display("FAIL rise_no_change: busy=%b led0=%b expected 0/1", busy_a, led_out_a[0]);
        end
        led_in_a = 10'h000;
        count_hi(0, 3074, 3329, cnt);
        n_tests++;
        if (cnt !== 239) begin
            n_fail++; $display("FAIL rise_then_down: got %0d expected 239", cnt);
        end
    endtask

    task automatic test_reset_mid_fade();
        int cnt;
        n_tests++;
        if (busy_a !== 1'b1 || led_out_a[0] !== 1'b1) begin
            n_fail++; $display("FAIL midreset_pre: busy=%b led0=%b expected 1/1", busy_a, led_out_a[0]);
        end
        #3;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (busy_a !== 1'b0 || led_out_a !== 10'h000) begin
            n_fail++; $display("FAIL midreset_async: busy=%b out=%h expected 0/000", busy_a, led_out_a);
        end
        do_reset();
        fade_en_a = 1'b1;
        led_in_a  = 10'h001;
        count_hi(0, 1026, 1281, cnt);
        n_tests++;
        if (cnt !== 16) begin
            n_fail++; $display("FAIL midreset_restart: got %0d expected 16", cnt);
        end
    endtask

    task automatic test_step255();
        int cnt;
        do_reset();
        fade_en_c = 1'b1;
        led_in_c  = 10'h001;
        wait_cyc(1024);
        n_tests++;
        if (busy_c !== 1'b1) begin
            n_fail++; $display("FAIL s255_busy_pre: got %b expected 1", busy_c);
        end
        tick();
        n_tests++;
        if (busy_c !== 1'b0) begin
            n_fail++; $display("FAIL s255_busy_post: got %b expected 0", busy_c);
        end
        count_hi(2, 1026, 1281, cnt);
        n_tests++;
        if (cnt !== 256) begin
            n_fail++; $display("FAIL s255_up: got %0d expected 256", cnt);
        end
        count_hi(2, 2050, 2305, cnt);
        n_tests++;
        if (cnt !== 256) begin
            n_fail++; $display("FAIL s255_no_overflow: got %0d expected 256", cnt);
        end
        led_in_c = 10'h000;
        count_hi(2, 3074, 3329, cnt);
        n_tests++;
        if (cnt !== 0) begin
            n_fail++; $display("FAIL s255_down: got %0d expected 0", cnt);
        end
        count_hi(2, 4098, 4353, cnt);
        n_tests++;
        if (cnt !== 0) begin
            n_fail++; $display("FAIL s255_no_underflow: got %0d expected 0", cnt);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        reset_n   = 1'b0;
        led_in_a  = '0; led_in_b  = '0; led_in_c  = '0;
        fade_en_a = 1'b0; fade_en_b = 1'b0; fade_en_c = 1'b0;
        test_reset();
        test_ramp_up();
        test_duty();
        test_ramp_down();
        test_snap();
        test_fade_en_fall();
        test_reset_mid_fade();
        test_step255();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
